// File: rtl/wb_rackctl_pkg.sv
// rtl/wb_rackctl_pkg.sv - shared constants and types for the RACKctl command bridge
//
// Purpose: command-address layout, timeout read-back pattern, FSM state
// encoding and termination kinds used by wb_rackctl_cmd_bridge.
package wb_rackctl_pkg;

  localparam int RACKCTL_ADDR_W  = 24;
  localparam int WB_ADR_W        = 22;
  localparam int RACKCTL_RNW_BIT = 23;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADDEAD;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RESP = 3'd2,
    ST_TERM      = 3'd3,
    ST_DRAIN     = 3'd4
  } bridge_state_e;

  typedef enum logic [1:0] {
    TERM_ACK = 2'd0,
    TERM_ERR = 2'd1,
    TERM_RTY = 2'd2
  } term_kind_e;

endpackage

// File: rtl/wb_rackctl_cmd_bridge.sv
// rtl/wb_rackctl_cmd_bridge.sv - WISHBONE slave to RACKctl command-buffer bridge
//
// Purpose: turns one WB classic cycle into one command (24-bit address,
// 32-bit data, valid/ack) and returns the single-strobe response as the WB
// termination. One outstanding command; a counter bounds the wait for the
// response and a timeout terminates with a failure.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wb_cyc_i .. wb_sel_i      WB slave request
//   wb_ack_o/err_o/rty_o      WB termination (single-cycle pulse)
//   wb_dat_o                  WB read data, valid with the termination pulse
//   cmd_addr_o/data_o/valid_o command to the RACKctl master, cmd_ack_i accepts
//   resp_data_i/valid_i/err_i response strobe from the RACKctl master
//
// Build option: WB_RACKCTL_BRIDGE_RETRY_EN - timeouts and error responses
// terminate with wb_rty_o instead of wb_err_o; undefined ties wb_rty_o low.
module wb_rackctl_cmd_bridge
  import wb_rackctl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter string       DEBUG          = "FALSE"
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [WB_ADR_W-1:0]       wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  input  logic [3:0]                wb_sel_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  output logic [31:0]               wb_dat_o,
  output logic [RACKCTL_ADDR_W-1:0] cmd_addr_o,
  output logic [31:0]               cmd_data_o,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ack_i,
  input  logic [31:0]               resp_data_i,
  input  logic                      resp_valid_i,
  input  logic                      resp_err_i
);

  localparam logic [2:0] IDLE      = ST_IDLE;
  localparam logic [2:0] ISSUE     = ST_ISSUE;
  localparam logic [2:0] WAIT_RESP = ST_WAIT_RESP;
  localparam logic [2:0] TERM      = ST_TERM;
  localparam logic [2:0] DRAIN     = ST_DRAIN;

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef WB_RACKCTL_BRIDGE_RETRY_EN
  localparam term_kind_e FAIL_TERM = TERM_RTY;
`else
  localparam term_kind_e FAIL_TERM = TERM_ERR;
`endif

  logic [2:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_next;
  logic                      timeout_hit;
  logic                      abandon_q;
  term_kind_e                term_q;
  logic [31:0]               result_q;
  logic [RACKCTL_ADDR_W-1:0] issue_addr;

  always_comb begin
    issue_addr                  = {{(RACKCTL_ADDR_W - WB_ADR_W){1'b0}}, wb_adr_i};
    issue_addr[RACKCTL_RNW_BIT] = ~wb_we_i;
  end

  // Saturating counter; the timeout fires on the edge where it reaches the
  // terminal count, and stays asserted once saturated (used by DRAIN).
  assign cnt_next    = (cnt == CNT_TERM) ? cnt : cnt + 1'b1;
  assign timeout_hit = (cnt_next == CNT_TERM);

`ifndef WB_RACKCTL_BRIDGE_RETRY_EN
  assign wb_rty_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      abandon_q   <= 1'b0;
      term_q      <= TERM_ACK;
      result_q    <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
`ifdef WB_RACKCTL_BRIDGE_RETRY_EN
      wb_rty_o    <= 1'b0;
`endif
      wb_dat_o    <= '0;
      cmd_addr_o  <= '0;
      cmd_data_o  <= '0;
      cmd_valid_o <= 1'b0;
    end else begin
      // Termination and read data are single-cycle pulses.
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
`ifdef WB_RACKCTL_BRIDGE_RETRY_EN
      wb_rty_o <= 1'b0;
`endif
      wb_dat_o <= '0;

      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            if (wb_we_i && (wb_sel_i != 4'hF)) begin
              // The command path carries whole words only.
              term_q   <= TERM_ERR;
              result_q <= '0;
              state    <= TERM;
            end else begin
              cmd_addr_o  <= issue_addr;
              cmd_data_o  <= wb_we_i ? wb_dat_i : 32'h0;
              cmd_valid_o <= 1'b1;
              abandon_q   <= 1'b0;
              state       <= ISSUE;
            end
          end
        end

        ISSUE: begin
          // An abandoned cycle still has to push its command through.
          if (!wb_cyc_i) abandon_q <= 1'b1;
          if (cmd_ack_i) begin
            cmd_valid_o <= 1'b0;
            cmd_addr_o  <= '0;
            cmd_data_o  <= '0;
            cnt         <= '0;
            state       <= (abandon_q || !wb_cyc_i) ? DRAIN : WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          cnt <= cnt_next;
          if (resp_valid_i) begin
            result_q <= resp_data_i;
            term_q   <= resp_err_i ? FAIL_TERM : TERM_ACK;
            state    <= TERM;
          end else if (!wb_cyc_i) begin
            state <= DRAIN;
          end else if (timeout_hit) begin
            result_q <= TIMEOUT_DATA;
            term_q   <= FAIL_TERM;
            state    <= TERM;
          end
        end

        TERM: begin
          if (wb_cyc_i && wb_stb_i) begin
            wb_dat_o <= result_q;
            case (term_q)
              TERM_ACK: wb_ack_o <= 1'b1;
              TERM_ERR: wb_err_o <= 1'b1;
`ifdef WB_RACKCTL_BRIDGE_RETRY_EN
              default:  wb_rty_o <= 1'b1;
`else
              default:  wb_err_o <= 1'b1;
`endif
            endcase
          end
          state <= IDLE;
        end

        DRAIN: begin
          cnt <= cnt_next;
          if (resp_valid_i || timeout_hit) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (DEBUG == "TRUE") begin : g_ila
      (* mark_debug = "true" *) logic [2:0]       ila_state_unused;
      (* mark_debug = "true" *) logic [CNT_W-1:0] ila_cnt_unused;
      assign ila_state_unused = state;
      assign ila_cnt_unused   = cnt;
    end
  endgenerate

endmodule

// File: doc/wb_rackctl_cmd_bridge.md
Name: wb_rackctl_cmd_bridge

Overview:
Host-side WISHBONE slave that turns single WB cycles into command-buffer transactions (24-bit address, 32-bit data, valid/ack). It feeds the mode-1 command path of the RACKctl WB master and returns the transaction response to the WB initiator. The block is the responder for the command interface that the RACKctl master consumes. A timeout counter bounds every transaction; a timed-out transaction terminates with an error.

Parameters:
TIMEOUT_CYCLES, 1024, wb_clk_i cycles allowed from the cmd_ack_i handshake to resp_valid_i before the block gives up (minimum 2).
DEBUG, "FALSE", "TRUE" exposes the FSM state and timeout counter to ILA marking.

Ports:
wb_clk_i  in  1  WB clock; the only clock.
wb_rst_i  in  1  synchronous active-high reset.
wb_cyc_i  in  1  WB cycle.
wb_stb_i  in  1  WB strobe.
wb_we_i  in  1  WB write enable.
wb_adr_i  in  22  WB word address.
wb_dat_i  in  32  WB write data.
wb_sel_i  in  4  WB byte selects.
wb_ack_o  out  1  WB acknowledge.
wb_err_o  out  1  WB error.
wb_rty_o  out  1  WB retry.
wb_dat_o  out  32  WB read data.
cmd_addr_o  out  24  [23] = read-not-write (1 = read), [22] = 0, [21:0] = wb_adr_i.
cmd_data_o  out  32  write data; 0 for reads.
cmd_valid_o  out  1  command valid.
cmd_ack_i  in  1  command accepted.
resp_data_i  in  32  response data (read data, or echo for writes).
resp_valid_i  in  1  single-cycle response strobe.
resp_err_i  in  1  qualifies resp_valid_i; the downstream target returned err or rty.

Behaviour:
- Reset, and the IDLE state: all outputs 0, counter 0, state IDLE. Reset mid-transaction abandons it immediately. No WB termination is issued and cmd_valid_o drops on the next edge.
- FSM states: IDLE, ISSUE, WAIT_RESP, TERM, DRAIN.
- IDLE, when wb_cyc_i && wb_stb_i:
  - If wb_we_i && wb_sel_i != 4'hF: go to TERM with err. The protocol carries full words only.
  - Otherwise: register cmd_addr_o, cmd_data_o and the rnw bit, then go to ISSUE.
- ISSUE: cmd_valid_o = 1 and is held with stable data until cmd_ack_i. On the cmd_ack_i cycle, go to WAIT_RESP, clear the counter and drop cmd_valid_o on the next edge. ISSUE has no timeout; the command buffer guarantees acceptance.
- WAIT_RESP: the counter increments each cycle.
  - resp_valid_i: capture resp_data_i into wb_dat_o, go to TERM; terminate with err if resp_err_i, otherwise ack.
  - Counter reaching TIMEOUT_CYCLES-1 without a response: go to TERM with err. wb_dat_o = 32'hDEADDEAD.
  - resp_valid_i on the same cycle as timeout: the response wins.
- TERM: exactly one of ack/err/rty is high for exactly one cycle, provided wb_cyc_i && wb_stb_i are still high. Then go to IDLE.
- Cycle abandoned: if wb_cyc_i falls in ISSUE or WAIT_RESP, the command still completes. The response is consumed (or the timeout expires) in DRAIN, the result is discarded and no WB termination is issued. If wb_cyc_i falls in TERM, go to IDLE silently.
- Latency: the WB strobe is registered in the IDLE cycle, and cmd_valid_o rises on the next edge. With cmd_ack_i and resp_valid_i both asserted on first opportunity, wb_ack_o is high 4 cycles after the strobe.
- Back-to-back cycles: a new strobe is only accepted from IDLE. There is no pipelining and at most one outstanding command.
- Stray responses: resp_valid_i outside WAIT_RESP/DRAIN is ignored.
- The counter is $clog2(TIMEOUT_CYCLES) bits and never wraps; it saturates at the terminal count.

Optional Feature:
Macro WB_RACKCTL_BRIDGE_RETRY_EN.
- Defined: a timeout terminates with wb_rty_o instead of wb_err_o, and a resp_err_i response also terminates with wb_rty_o.
- Undefined: wb_rty_o is tied to 0 and every failure terminates with wb_err_o.

Decomposition:
- Package wb_rackctl_pkg holds:
  - state enum;
  - RACKCTL_RNW_BIT = 23;
  - RACKCTL_ADDR_W = 24 and WB_ADR_W = 22;
  - TIMEOUT_DATA = 32'hDEADDEAD.
- No sub-module; the FSM and counter stay in one module.

Test Plan:
- Write adr 22'h000123, dat 32'hCAFEF00D, sel 4'hF -> cmd_addr_o = 24'h000123, cmd_data_o = 32'hCAFEF00D, cmd_valid_o held until ack. With resp_valid_i 3 cycles later, wb_ack_o pulses once.
- Read adr 22'h3FFFFF; resp_data_i = 32'h12345678 -> cmd_addr_o = 24'hBFFFFF, cmd_data_o = 0, wb_dat_o = 32'h12345678 with wb_ack_o.
- Write with sel 4'h3 -> no cmd_valid_o; wb_err_o pulses 2 cycles after the strobe.
- No response, TIMEOUT_CYCLES = 16 -> wb_err_o (wb_rty_o with the macro) 16 cycles after cmd_ack_i; wb_dat_o = 32'hDEADDEAD.
- Drop wb_cyc_i in WAIT_RESP, then respond -> no termination. A subsequent read completes normally with the new data.
- Assert wb_rst_i during ISSUE -> cmd_valid_o = 0 the next cycle, state IDLE, all WB outputs 0.
